// File: rtl/pipe_pkg.sv
// Shared types and default widths for the handshaked pipeline stage.
// The exception bundle layout is carried verbatim; stages never decode it.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_TWO   = 2'd2
   } pipe_state_e;

   typedef struct packed {
      logic       interrupt;
      logic [7:0] flags;
   } ExceptinPipeType;

   localparam int PIPE_DATA_W = 64;
   localparam int PIPE_EXC_W  = $bits(ExceptinPipeType);
   localparam int PIPE_CNT_W  = 32;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter with increment and clear, used for
// back-pressure statistics; holds at all-ones once reached.
module pipe_stall_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !(&cnt_q)) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with flush and stall counter.
// Define PIPE_SKID_BUFFER_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int EXC_W  = PIPE_EXC_W,
   parameter int CNT_W  = PIPE_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [EXC_W-1:0]  in_exc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [EXC_W-1:0]  out_exc,
   output logic [CNT_W-1:0]  stall_cnt
);

   pipe_state_e       state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [EXC_W-1:0]  exc_q, exc_d;
   logic              in_fire;
   logic              out_fire;

   assign out_valid = (state_q != PS_EMPTY);
   assign out_fire  = out_valid & out_ready;
   assign in_fire   = in_valid & in_ready;
   assign out_data  = data_q;
   assign out_exc   = exc_q;

`ifdef PIPE_SKID_BUFFER_EN
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [EXC_W-1:0]  skid_exc_q, skid_exc_d;
   logic              rdy_q;

   assign in_ready = rdy_q;

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      exc_d       = exc_q;
      skid_data_d = skid_data_q;
      skid_exc_d  = skid_exc_q;
      unique case (state_q)
         PS_EMPTY: begin
            if (in_fire) begin
               state_d = PS_ONE;
               data_d  = in_data;
               exc_d   = in_exc;
            end
         end
         PS_ONE: begin
            if (in_fire && out_fire) begin
               data_d = in_data;
               exc_d  = in_exc;
            end else if (in_fire) begin
               state_d     = PS_TWO;
               skid_data_d = in_data;
               skid_exc_d  = in_exc;
            end else if (out_fire) begin
               state_d = PS_EMPTY;
            end
         end
         PS_TWO: begin
            if (out_fire) begin
               state_d     = PS_ONE;
               data_d      = skid_data_q;
               exc_d       = skid_exc_q;
               skid_data_d = '0;
               skid_exc_d  = '0;
            end
         end
         default: state_d = PS_EMPTY;
      endcase
      // Flush drops everything, including an entry accepted this cycle
      if (flush) begin
         state_d     = PS_EMPTY;
         data_d      = '0;
         exc_d       = '0;
         skid_data_d = '0;
         skid_exc_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PS_EMPTY;
         data_q      <= '0;
         exc_q       <= '0;
         skid_data_q <= '0;
         skid_exc_q  <= '0;
         rdy_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         exc_q       <= exc_d;
         skid_data_q <= skid_data_d;
         skid_exc_q  <= skid_exc_d;
         rdy_q       <= (state_d != PS_TWO);
      end
   end
`else
   assign in_ready = (!out_valid | out_ready) & !flush;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      exc_d   = exc_q;
      if (in_fire) begin
         state_d = PS_ONE;
         data_d  = in_data;
         exc_d   = in_exc;
      end else if (out_fire) begin
         state_d = PS_EMPTY;
      end
      if (flush) begin
         state_d = PS_EMPTY;
         data_d  = '0;
         exc_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PS_EMPTY;
         data_q  <= '0;
         exc_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         exc_q   <= exc_d;
      end
   end
`endif

   pipe_stall_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (1'b0),
      .inc_i (out_valid & ~out_ready),
      .cnt_o (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: queue-based reference model plus directed
// literal checks, followed by randomized traffic with flush and reset.
module tb_pipe_stage_hs;

   localparam int DW = 64;
   localparam int EW = 9;
   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;
`ifdef PIPE_SKID_BUFFER_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [EW-1:0] in_exc;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [EW-1:0] out_exc;
   logic [CW-1:0] stall_cnt;

   pipe_stage_hs #(
      .DATA_W (DW),
      .EXC_W  (EW),
      .CNT_W  (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_exc    (in_exc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_exc   (out_exc),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [EW-1:0] e;
   } ent_t;

   ent_t        mq[$];
   ent_t        hold;
   int unsigned mstall;
   bit          chk_en;
   bit          acc;
   int          n_pass;
   int          n_total;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
   endtask

   // One clock: compare at negedge against the model, then advance it.
   task automatic step();
      bit   exp_rdy;
      bit   push;
      bit   pop;
      ent_t head;
      @(negedge clk);
      if (SKID) exp_rdy = (mq.size() < 2);
      else exp_rdy = (mq.size() == 0 || out_ready) && !flush;
      head = (mq.size() != 0) ? mq[0] : hold;
      if (chk_en) begin
         chk("in_ready", 64'(in_ready), 64'(exp_rdy));
         chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
         chk("out_data", out_data, head.d);
         chk("out_exc", 64'(out_exc), 64'(head.e));
         chk("stall_cnt", 64'(stall_cnt), 64'(mstall));
      end
      push = in_valid && exp_rdy;
      acc  = push || flush || rst;
      if (rst) begin
         mq.delete();
         hold   = '0;
         mstall = 0;
      end else begin
         if (mq.size() != 0 && !out_ready && mstall < SAT) mstall++;
         if (flush) begin
            mq.delete();
            hold = '0;
         end else begin
            pop = (mq.size() != 0) && out_ready;
            if (pop) hold = mq.pop_front();
            if (push) mq.push_back({in_data, in_exc});
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      chk_en    = 1'b0;
      mstall    = 0;
      hold      = '0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hDEAD;
      in_exc    = '0;
      out_ready = 1'b0;
      step();
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk_en   = 1'b1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_stall", 64'(stall_cnt), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);

      // streaming 0..7, one per cycle
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_data  = 64'(k);
         step();
         chk("stream_valid", 64'(out_valid), 64'd1);
         chk("stream_data", out_data, 64'(k));
      end
      in_valid = 1'b0;
      step();
      chk("stream_stall", 64'(stall_cnt), 64'd0);

      // back-pressure then saturation
      in_valid = 1'b1;
      in_data  = 64'h77;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) step();
      chk("bp_data", out_data, 64'h77);
      chk("bp_stall", 64'(stall_cnt), 64'd5);
`ifndef PIPE_SKID_BUFFER_EN
      in_valid = 1'b1;
      chk("bp_ready_lo", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      #1;
      chk("bp_ready_hi", 64'(in_ready), 64'd1);
      out_ready = 1'b0;
      in_valid  = 1'b0;
`endif
      for (int k = 0; k < 20; k++) step();
      chk("sat_stall", 64'(stall_cnt), 64'(SAT));

      // flush while full with a new entry offered
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 64'h1234;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_data", out_data, 64'd0);
      chk("fl_exc", 64'(out_exc), 64'd0);
      out_ready = 1'b1;
      step();
      step();
      chk("fl_gone", 64'(out_valid), 64'd0);

      // exception passthrough
      in_valid = 1'b1;
      in_data  = 64'hA5;
      in_exc   = 9'b100000000;
      step();
      in_valid = 1'b0;
      in_exc   = '0;
      chk("exc_vec", 64'(out_exc), 64'h100);
      chk("exc_data", out_data, 64'hA5);
      step();

`ifdef PIPE_SKID_BUFFER_EN
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hA;
      step();
      in_data = 64'hB;
      step();
      in_valid = 1'b0;
      chk("skid_full", 64'(in_ready), 64'd0);
      chk("skid_headA", out_data, 64'hA);
      out_ready = 1'b1;
      step();
      chk("skid_headB", out_data, 64'hB);
      chk("skid_rdy", 64'(in_ready), 64'd1);
      step();
      chk("skid_empty", 64'(out_valid), 64'd0);
`endif

      // randomized traffic
      in_valid = 1'b0;
      acc      = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 99) < 70);
            in_data  = {$urandom, $urandom};
            in_exc   = 9'($urandom);
         end
         out_ready = ($urandom_range(0, 99) < 60);
         flush     = ($urandom_range(0, 99) < 4);
         rst       = ($urandom_range(0, 299) == 0);
         step();
      end
      rst   = 1'b0;
      flush = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
